// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory-side responder and its RAM.
package mem_responder_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SERVE,
    ST_DUMP,
    ST_DONE
  } state_e;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous RAM; registered read returns the pre-write word.
module resp_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Stages one master run: host load, master read/write service, full-store dump.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic              rden,
  input  logic              wren,
  input  logic [DATA_W-1:0] dataout,
  output logic [DATA_W-1:0] datain,
  input  logic              ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] ZERO      = DATA_W'(ZERO_WORD);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] lptr_q, lptr_d;
  logic [ADDR_W-1:0] dptr_q, dptr_d;
  logic              rd_q, dv_q, done_q;
  logic [ADDR_W-1:0] daddr_q;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      lptr_q  <= '0;
      dptr_q  <= '0;
      rd_q    <= 1'b0;
      dv_q    <= 1'b0;
      daddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lptr_q  <= lptr_d;
      dptr_q  <= dptr_d;
      rd_q    <= (state_q == ST_SERVE) && rden;
      dv_q    <= (state_q == ST_DUMP);
      daddr_q <= (state_q == ST_DUMP) ? dptr_q : '0;
      done_q  <= (state_q == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    lptr_d  = lptr_q;
    dptr_d  = dptr_q;
    case (state_q)
      ST_LOAD: if (load_valid) begin
        lptr_d = lptr_q + 1'b1;
        if (load_last || lptr_q == LAST_ADDR) begin
          state_d = ST_SERVE;
          lptr_d  = '0;
        end
      end
      ST_SERVE: if (ready) begin
        state_d = ST_DUMP;
        dptr_d  = '0;
      end
      ST_DUMP: begin
        dptr_d = dptr_q + 1'b1;
        if (dptr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          dptr_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // RAM port source follows the state; reset kills writes in the same cycle.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = ZERO;
    case (state_q)
      ST_LOAD: begin
        ram_addr  = lptr_q;
        ram_we    = load_valid;
        ram_wdata = load_data;
      end
      ST_SERVE: begin
        ram_addr  = address;
        ram_we    = wren;
        ram_wdata = dataout;
      end
      ST_DUMP: ram_addr = dptr_q;
      default: ;
    endcase
    ram_we     = ram_we && !reset;
    load_ready = (state_q == ST_LOAD) || reset;
    start      = (state_q == ST_SERVE) && !reset;
    datain     = (rd_q && !reset) ? ram_rdata : ZERO;
    dump_valid = dv_q && !reset;
    dump_addr  = reset ? '0 : daddr_q;
    dump_data  = (dv_q && !reset) ? ram_rdata : ZERO;
    done       = done_q && !reset;
  end

  resp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: vector table, random master traffic against an array model, dump/reset sequences.
module tb_mem_responder;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid, load_last, load_ready, start;
  logic [DW-1:0] load_data;
  logic [AW-1:0] address;
  logic          rden, wren, ready;
  logic [DW-1:0] dataout, datain;
  logic          dump_valid, done;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;

  mem_responder dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start),
    .address(address), .rden(rden), .wren(wren), .dataout(dataout),
    .datain(datain), .ready(ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl[8];
  logic [DW-1:0] mem_m [DP];
  int            nvec = 0;
  int            nmis = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs;
    load_valid = 0; load_last = 0; load_data = '0;
    rden = 0; wren = 0; address = '0; dataout = '0; ready = 0;
  endtask

  // One master cycle; expectation comes from the array model (read sees the old word).
  task automatic serve_op(input string nm, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] exp;
    exp = rd ? mem_m[a] : '0;
    rden = rd; wren = wr; address = a; dataout = wd;
    tick();
    chk(nm, datain, exp);
    if (wr) mem_m[a] = wd;
    rden = 0; wren = 0;
  endtask

  // Pulse ready in SERVE and check the dump; abort_at >= 0 asserts reset at that word.
  task automatic run_dump(input int abort_at);
    ready = 1;
    tick();
    ready = 0;
    chk("start_drop", start, 0);
    chk("dump_gap0", dump_valid, 0);
    for (int k = 0; k < DP; k++) begin
      tick();
      chk($sformatf("dv%0d", k), dump_valid, 1);
      chk($sformatf("da%0d", k), dump_addr, k);
      chk($sformatf("dd%0d", k), dump_data, mem_m[k]);
      if (k == abort_at) begin
        reset = 1;
        #1;
        chk("rst_dv_hi", dump_valid, 0);
        chk("rst_lr_hi", load_ready, 1);
        tick();
        reset = 0;
        chk("rst_lr", load_ready, 1);
        chk("rst_dv", dump_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_start", start, 0);
        return;
      end
    end
    tick();
    chk("done_n33", done, 1);
    chk("dv_end", dump_valid, 0);
  endtask

  initial begin
    tbl[0] = '{1, 0, 5'd1, 16'd0,  16'd7};
    tbl[1] = '{0, 0, 5'd1, 16'd0,  16'd0};
    tbl[2] = '{0, 1, 5'd2, 16'd12, 16'd0};
    tbl[3] = '{1, 0, 5'd2, 16'd0,  16'd12};
    tbl[4] = '{1, 1, 5'd0, 16'd9,  16'd5};
    tbl[5] = '{1, 0, 5'd0, 16'd0,  16'd9};
    tbl[6] = '{1, 0, 5'd2, 16'd0,  16'd12};
    tbl[7] = '{0, 0, 5'd0, 16'd0,  16'd0};

    idle_inputs();
    reset = 1;
    tick();
    tick();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_datain", datain, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    reset = 0;
    tick();
    chk("post_rst_lr", load_ready, 1);
    chk("post_rst_start", start, 0);

    // Full load without load_last: SERVE entered after the 32nd word.
    for (int i = 0; i < DP; i++) begin
      load_valid = 1; load_data = DW'(i); load_last = 0;
      tick();
      mem_m[i] = DW'(i);
      if (i == DP - 2) chk("start_before_full", start, 0);
    end
    chk("start_after_full", start, 1);
    chk("lr_after_full", load_ready, 0);
    load_data = 16'hBEEF;
    tick();
    load_valid = 0;
    serve_op("wrap_mem0", 1, 0, 5'd0, 16'd0);

    for (int i = 0; i < 200; i++) begin
      serve_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom),
               AW'($urandom_range(0, DP - 1)), DW'($urandom));
    end

    run_dump(-1);
    for (int i = 0; i < 3; i++) begin
      rden = 1; wren = 1; address = 5'd5; dataout = 16'hFFFF; ready = 1;
      tick();
      chk("done_hold", done, 1);
      chk("done_datain", datain, 0);
      chk("done_start", start, 0);
      chk("done_dv", dump_valid, 0);
    end
    idle_inputs();

    reset = 1;
    tick();
    reset = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      rden = 1; wren = 1; address = 5'd6; dataout = 16'hAAAA; ready = 1;
      tick();
      chk("load_ign_datain", datain, 0);
      chk("load_ign_start", start, 0);
      chk("load_ign_lr", load_ready, 1);
    end
    idle_inputs();

    load_valid = 1; load_data = 16'd5; tick();
    load_data = 16'd7; tick();
    chk("start_mid_load", start, 0);
    load_data = 16'd0; load_last = 1; tick();
    load_valid = 0; load_last = 0;
    mem_m[0] = 16'd5; mem_m[1] = 16'd7; mem_m[2] = 16'd0;
    chk("start_after_last", start, 1);

    for (int i = 0; i < 8; i++) begin
      rden = tbl[i].rd; wren = tbl[i].wr; address = tbl[i].a; dataout = tbl[i].wd;
      tick();
      chk($sformatf("tbl%0d", i), datain, tbl[i].exp);
      if (tbl[i].wr) mem_m[tbl[i].a] = tbl[i].wd;
    end
    rden = 0; wren = 0;

    run_dump(10);
    tick();
    chk("abort_no_dump", dump_valid, 0);
    load_valid = 1; load_data = 16'd3; load_last = 1;
    tick();
    load_valid = 0; load_last = 0;
    mem_m[0] = 16'd3;
    chk("reload_start", start, 1);
    serve_op("retain_a1", 1, 0, 5'd1, 16'd0);
    serve_op("reload_a0", 1, 0, 5'd0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
